// File: rtl/ps2_mouse_pkg.sv
// Shared PS/2 mouse definitions: command/response bytes, FSM encoding, packet byte-0 layout.
// Used by the device-side stream responder and the host stream FSM alike.
package ps2_mouse_pkg;

  localparam logic [7:0] CMD_STREAM_ON  = 8'hF4;
  localparam logic [7:0] CMD_STREAM_OFF = 8'hF5;
  localparam logic [7:0] CMD_GET_ID     = 8'hF2;
  localparam logic [7:0] CMD_RESET      = 8'hFF;

  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
  localparam logic [7:0] RSP_DEV_ID  = 8'h00;

  typedef enum logic [3:0] {
    ST_BAT, ST_BAT_W, ST_ID, ST_ID_W, ST_IDLE, ST_ACK, ST_ACK_W,
    ST_PK1, ST_PK1_W, ST_PK2, ST_PK2_W, ST_PK3, ST_PK3_W
  } state_t;

  localparam int B0_Y_OVF  = 7;
  localparam int B0_X_OVF  = 6;
  localparam int B0_Y_SIGN = 5;
  localparam int B0_X_SIGN = 4;
  localparam int B0_ONE    = 3;

  // Returns {overflow, sum} with the sum clamped to -256..+255.
  function automatic logic [9:0] sat_add9(input logic signed [8:0] a, input logic signed [8:0] b);
    logic signed [9:0] s;
    s = $signed({a[8], a}) + $signed({b[8], b});
    if (s > 10'sd255)
      return {1'b1, 9'h0FF};
    else if (s < -10'sd256)
      return {1'b1, 9'h100};
    else
      return {1'b0, s[8:0]};
  endfunction

endpackage

// File: rtl/mouse_stream_responder_if.sv
// Byte receiver/transmitter handshake plus motion inputs of the mouse stream responder.
// master = host/emulation side driving commands and motion, slave = the responder.
interface mouse_stream_responder_if;
  logic [7:0]        rx_data;
  logic              rx_done_tick;
  logic              tx_done_tick;
  logic              move_valid;
  logic signed [8:0] dx;
  logic signed [8:0] dy;
  logic [2:0]        btn;
  logic              wr_ps2;
  logic [7:0]        tx_data;
  logic              stream_en;
  logic              package_sent_tick;

  modport master (
    output rx_data, rx_done_tick, tx_done_tick, move_valid, dx, dy, btn,
    input  wr_ps2, tx_data, stream_en, package_sent_tick
  );

  modport slave (
    input  rx_data, rx_done_tick, tx_done_tick, move_valid, dx, dy, btn,
    output wr_ps2, tx_data, stream_en, package_sent_tick
  );
endinterface

// File: rtl/mouse_motion_acc.sv
// Saturating dx/dy accumulator pair with sticky overflow flags; clear zeroes both (snapshot or reset).
// One-cycle update; a move on the clear cycle lands in the freshly cleared sums.
module mouse_motion_acc
  import ps2_mouse_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              move_valid,
  input  logic signed [8:0] dx,
  input  logic signed [8:0] dy,
  input  logic              clear,
  output logic signed [8:0] acc_x,
  output logic signed [8:0] acc_y,
  output logic              x_ovf,
  output logic              y_ovf
);

  logic signed [8:0] base_x, base_y;
  logic              base_xo, base_yo;
  logic [9:0]        sum_x, sum_y;

  always_comb begin
    base_x  = clear ? '0   : acc_x;
    base_y  = clear ? '0   : acc_y;
    base_xo = clear ? 1'b0 : x_ovf;
    base_yo = clear ? 1'b0 : y_ovf;
    sum_x   = sat_add9(base_x, dx);
    sum_y   = sat_add9(base_y, dy);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_x <= '0;
      acc_y <= '0;
      x_ovf <= 1'b0;
      y_ovf <= 1'b0;
    end else if (en && move_valid) begin
      acc_x <= sum_x[8:0];
      acc_y <= sum_y[8:0];
      x_ovf <= base_xo | sum_x[9];
      y_ovf <= base_yo | sum_y[9];
    end else begin
      acc_x <= base_x;
      acc_y <= base_y;
      x_ovf <= base_xo;
      y_ovf <= base_yo;
    end
  end

endmodule

// File: rtl/mouse_stream_responder.sv
// Device-side PS/2 mouse: answers host commands and streams 3-byte movement packets at the sample rate.
// wr_ps2 follows a send state by one cycle; each byte waits for tx_done_tick before the next is issued.
module mouse_stream_responder
  import ps2_mouse_pkg::*;
#(
  parameter int SAMPLE_DIV = 500000
)
(
  input  logic                      clk,
  input  logic                      rst_n,
  mouse_stream_responder_if.slave   bus
);

  localparam int              CW       = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(SAMPLE_DIV - 1);

  state_t            state, state_nx;
  logic [CW-1:0]     rate_cnt;
  logic              rate_tick;
  logic [7:0]        cmd, cmd_buf;
  logic              cmd_pend;
  logic [7:0]        pkt_b0, pkt_x, pkt_y;
  logic [2:0]        last_btn;
  logic signed [8:0] acc_x, acc_y;
  logic              x_ovf, y_ovf;
  logic              pending, in_pkt, cmd_hit, snap, clr;
  logic              wr_nx;
  logic [7:0]        tx_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rate_cnt <= '0;
    else if (rate_tick) rate_cnt <= '0;
    else                rate_cnt <= rate_cnt + CW'(1);
  end

  assign rate_tick = (rate_cnt == CNT_LAST);
  assign pending   = (acc_x != '0) || (acc_y != '0) || x_ovf || y_ovf || (bus.btn != last_btn);
  assign in_pkt    = state inside {ST_PK1, ST_PK1_W, ST_PK2, ST_PK2_W, ST_PK3, ST_PK3_W};
  // A command during a packet (buffered or arriving now) truncates the packet after the current byte.
  assign cmd_hit   = in_pkt && (bus.rx_done_tick || cmd_pend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BAT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_BAT:   state_nx = ST_BAT_W;
      ST_BAT_W: if (bus.tx_done_tick) state_nx = ST_ID;
      ST_ID:    state_nx = ST_ID_W;
      ST_ID_W:  if (bus.tx_done_tick) state_nx = ST_IDLE;
      ST_IDLE: begin
        if (bus.rx_done_tick)                          state_nx = ST_ACK;
        else if (bus.stream_en && rate_tick && pending) state_nx = ST_PK1;
      end
      ST_ACK:   state_nx = ST_ACK_W;
      ST_ACK_W: begin
        if (bus.tx_done_tick) begin
          case (cmd)
            CMD_GET_ID: state_nx = ST_ID;
            CMD_RESET:  state_nx = ST_BAT;
            default:    state_nx = ST_IDLE;
          endcase
        end
      end
      ST_PK1:   state_nx = ST_PK1_W;
      ST_PK1_W: if (bus.tx_done_tick) state_nx = cmd_hit ? ST_ACK : ST_PK2;
      ST_PK2:   state_nx = ST_PK2_W;
      ST_PK2_W: if (bus.tx_done_tick) state_nx = cmd_hit ? ST_ACK : ST_PK3;
      ST_PK3:   state_nx = ST_PK3_W;
      ST_PK3_W: if (bus.tx_done_tick) state_nx = cmd_hit ? ST_ACK : ST_IDLE;
      default:  state_nx = ST_BAT;
    endcase
  end

  always_comb begin
    wr_nx = 1'b0;
    tx_nx = bus.tx_data;
    case (state)
      ST_BAT: begin wr_nx = 1'b1; tx_nx = RSP_BAT_OK; end
      ST_ID:  begin wr_nx = 1'b1; tx_nx = RSP_DEV_ID; end
      ST_ACK: begin
        wr_nx = 1'b1;
        tx_nx = (cmd inside {CMD_STREAM_ON, CMD_STREAM_OFF, CMD_GET_ID, CMD_RESET}) ? RSP_ACK : RSP_RESEND;
      end
      ST_PK1: begin wr_nx = 1'b1; tx_nx = pkt_b0; end
      ST_PK2: begin wr_nx = 1'b1; tx_nx = pkt_x;  end
      ST_PK3: begin wr_nx = 1'b1; tx_nx = pkt_y;  end
      default: ;
    endcase
    snap                  = (state == ST_IDLE) && (state_nx == ST_PK1);
    clr                   = (state == ST_ACK_W) && bus.tx_done_tick && (cmd == CMD_RESET);
    bus.package_sent_tick = (state == ST_PK3_W) && bus.tx_done_tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wr_ps2    <= 1'b0;
      bus.tx_data   <= 8'h00;
      bus.stream_en <= 1'b0;
      cmd           <= 8'h00;
      cmd_buf       <= 8'h00;
      cmd_pend      <= 1'b0;
      pkt_b0        <= 8'h00;
      pkt_x         <= 8'h00;
      pkt_y         <= 8'h00;
      last_btn      <= 3'b000;
    end else begin
      bus.wr_ps2  <= wr_nx;
      bus.tx_data <= tx_nx;
      if (state == ST_ACK_W && bus.tx_done_tick) begin
        if (cmd == CMD_STREAM_ON)                                bus.stream_en <= 1'b1;
        else if (cmd == CMD_STREAM_OFF || cmd == CMD_RESET)      bus.stream_en <= 1'b0;
      end
      if (state_nx == ST_ACK) begin
        cmd      <= bus.rx_done_tick ? bus.rx_data : cmd_buf;
        cmd_pend <= 1'b0;
      end else if (in_pkt && bus.rx_done_tick) begin
        cmd_buf  <= bus.rx_data;
        cmd_pend <= 1'b1;
      end
      if (snap) begin
        pkt_b0   <= {y_ovf, x_ovf, acc_y[8], acc_x[8], 1'b1, bus.btn};
        pkt_x    <= acc_x[7:0];
        pkt_y    <= acc_y[7:0];
        last_btn <= bus.btn;
      end
    end
  end

  mouse_motion_acc u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (bus.stream_en && !clr),
    .move_valid (bus.move_valid),
    .dx         (bus.dx),
    .dy         (bus.dy),
    .clear      (snap || clr),
    .acc_x      (acc_x),
    .acc_y      (acc_y),
    .x_ovf      (x_ovf),
    .y_ovf      (y_ovf)
  );

endmodule

// File: tb/tb_mouse_stream_responder.sv
// Scoreboard bench: expected transmit bytes are queued with each stimulus and checked as wr_ps2 fires.
module tb_mouse_stream_responder;

  localparam int DIV = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mouse_stream_responder_if bus ();

  mouse_stream_responder #(.SAMPLE_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         checks  = 0;
  int         errors  = 0;
  int         n_bytes = 0;
  int         pkt_cnt = 0;
  int         cyc     = 0;
  bit         busy    = 1'b0;
  logic [7:0] exp_q[$];

  // Cycle position within the sample period, counted the same way from reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
  endtask

  // Monitor: every transmitted byte is compared with the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.wr_ps2) begin
          n_bytes++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", bus.tx_data);
          end else begin
            check("tx_byte", bus.tx_data, exp_q.pop_front());
          end
        end
        if (bus.package_sent_tick) pkt_cnt++;
      end
    end
  end

  // Transmitter model: finishes each byte 10 cycles after wr_ps2; a reset abandons the byte.
  initial begin
    bit ok;
    bus.tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.wr_ps2) begin
        busy = 1'b1;
        ok   = 1'b1;
        for (int i = 0; i < 10; i++) begin
          @(posedge clk);
          if (!rst_n) begin
            ok = 1'b0;
            break;
          end
        end
        if (ok) begin
          #1 bus.tx_done_tick = 1'b1;
          @(posedge clk);
          #1 bus.tx_done_tick = 1'b0;
        end
        busy = 1'b0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d bytes outstanding expected 0", name, exp_q.size());
    end
    cycles(3);
  endtask

  task automatic wait_bytes(input int target);
    int n = 0;
    while (n_bytes < target && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_bytes_timeout: got %0d bytes expected %0d", n_bytes, target);
    end
  endtask

  task automatic wait_phase(input int p);
    do begin
      @(posedge clk);
      #1;
    end while ((cyc % DIV) != p);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    bus.rx_data      = b;
    bus.rx_done_tick = 1'b1;
    @(posedge clk);
    #1 bus.rx_done_tick = 1'b0;
  endtask

  task automatic do_move(input int x, input int y);
    bus.dx         = 9'(x);
    bus.dy         = 9'(y);
    bus.move_valid = 1'b1;
    @(posedge clk);
    #1 bus.move_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    bus.rx_data      = 8'h00;
    bus.rx_done_tick = 1'b0;
    bus.move_valid   = 1'b0;
    bus.dx           = '0;
    bus.dy           = '0;
    bus.btn          = 3'b000;
    cycles(3);

    check("reset_wr_ps2",   bus.wr_ps2,            0);
    check("reset_tx_data",  bus.tx_data,           8'h00);
    check("reset_stream",   bus.stream_en,         0);
    check("reset_pkt_tick", bus.package_sent_tick, 0);

    // Power-on: self-test pass then device ID, no streaming.
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h00);
    @(negedge clk) rst_n = 1'b1;
    cycles(1);
    wait_idle("bat");
    check("bat_stream_off", bus.stream_en, 0);
    cycles(2 * DIV);
    check("bat_no_packet", pkt_cnt, 0);

    // Enable streaming, one basic packet.
    exp_q.push_back(8'hFA);
    send_cmd(8'hF4);
    wait_idle("f4");
    check("f4_stream_on", bus.stream_en, 1);
    wait_phase(2);
    push3(8'h29, 8'h05, 8'hFD);
    bus.btn = 3'b001;
    do_move(5, -3);
    wait_idle("pkt_basic");
    check("pkt_basic_count", pkt_cnt, 1);

    // Saturation: 3 x +200 clamps to +255 with X overflow.
    wait_phase(2);
    push3(8'h49, 8'hFF, 8'h00);
    do_move(200, 0);
    do_move(200, 0);
    do_move(200, 0);
    wait_idle("pkt_sat");
    check("pkt_sat_count", pkt_cnt, 2);
    cycles(DIV);
    push3(8'h09, 8'h01, 8'h00);
    wait_phase(2);
    do_move(1, 0);
    wait_idle("pkt_after_sat");
    check("pkt_after_sat_count", pkt_cnt, 3);

    // Unknown command during PK2: PK2 completes, PK3 dropped, resend answered.
    base = n_bytes;
    exp_q.push_back(8'h09);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'hFE);
    wait_phase(2);
    do_move(2, 1);
    wait_bytes(base + 2);
    cycles(3);
    send_cmd(8'h55);
    wait_idle("abort");
    check("abort_no_pkt_tick", pkt_cnt, 3);
    check("abort_stream_on", bus.stream_en, 1);

    // Move in the same cycle as the snapshot lands in the next packet.
    push3(8'h09, 8'h03, 8'h00);
    push3(8'h09, 8'h01, 8'h00);
    wait_phase(2);
    do_move(3, 0);
    wait_phase(DIV - 1);
    do_move(1, 0);
    wait_idle("snap_move");
    check("snap_move_count", pkt_cnt, 5);

    // Reset command while streaming.
    push3(8'hFA, 8'hAA, 8'h00);
    send_cmd(8'hFF);
    wait_idle("ff");
    check("ff_stream_off", bus.stream_en, 0);
    do_move(4, 0);
    cycles(2 * DIV);
    check("ff_no_packet", pkt_cnt, 5);

    // Get ID.
    exp_q.push_back(8'hFA);
    exp_q.push_back(8'h00);
    send_cmd(8'hF2);
    wait_idle("f2");
    check("f2_stream_off", bus.stream_en, 0);

    // Hardware reset in the middle of the FA byte.
    base = n_bytes;
    exp_q.push_back(8'hFA);
    send_cmd(8'hF4);
    wait_bytes(base + 1);
    cycles(3);
    rst_n = 1'b0;
    #1;
    check("midbyte_wr_ps2",  bus.wr_ps2,  0);
    check("midbyte_tx_data", bus.tx_data, 8'h00);
    exp_q.delete();
    cycles(3);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h00);
    @(negedge clk) rst_n = 1'b1;
    cycles(1);
    wait_idle("rebat");
    check("rebat_stream_off", bus.stream_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
